// File: rtl/instr_issuer.sv
// Program sequencer: loadable instruction memory issued in order onto a registered
// 32-bit bus, with NOP bubbles between words and a NOP drain tail before done.
module instr_issuer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int GAP   = 1,
  parameter int DRAIN = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          start,
  input  logic [AW:0]   length,
  output logic [31:0]   instruction,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   issued_count,
  output logic [AW:0]   invalid_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_DRAIN} state_t;

  state_t        state, state_d;
  logic [31:0]   mem [DEPTH];
  logic [AW:0]   len_q, len_d, clamped;
  logic [7:0]    cnt, cnt_d;
  logic [AW-1:0] pc_d, rd_addr;
  logic [31:0]   instr_d, word;
  logic          done_d, busy_d, issue;
  logic [AW:0]   issued_d, invalid_d;

  // Opcodes that the register file accepts as writes.
  function automatic logic opcode_valid(input logic [5:0] op);
    case (op)
      6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd10, 6'd12, 6'd13, 6'd15: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign clamped = (length > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : length;
  assign rd_addr = (state == S_IDLE) ? '0 : pc + 1'b1;
  assign word    = mem[rd_addr];

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d   = state;
    pc_d      = pc;
    cnt_d     = cnt;
    len_d     = len_q;
    instr_d   = '0;
    done_d    = 1'b0;
    issued_d  = issued_count;
    invalid_d = invalid_count;
    issue     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          issued_d  = '0;
          invalid_d = '0;
          if (clamped == '0) begin
            done_d = 1'b1;
          end else begin
            len_d   = clamped;
            pc_d    = '0;
            issue   = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if ({1'b0, pc} == len_q - 1'b1) begin
          cnt_d = '0;
          if (DRAIN == 0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (GAP > 0) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          pc_d  = pc + 1'b1;
          issue = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == 8'(GAP - 1)) begin
          pc_d    = pc + 1'b1;
          issue   = 1'b1;
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt == 8'(DRAIN - 1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Counts are applied after the clear above so the first word of a run counts as 1.
    if (issue) begin
      instr_d  = word;
      issued_d = issued_d + 1'b1;
      if (!opcode_valid(word[5:0])) invalid_d = invalid_d + 1'b1;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      instruction   <= '0;
      pc            <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      issued_count  <= '0;
      invalid_count <= '0;
      cnt           <= '0;
      len_q         <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state         <= state_d;
      instruction   <= instr_d;
      pc            <= pc_d;
      busy          <= busy_d;
      done          <= done_d;
      issued_count  <= issued_d;
      invalid_count <= invalid_d;
      cnt           <= cnt_d;
      len_q         <= len_d;
    end
  end

  // NOTE: program memory has no reset, so its contents survive rst; a write on the
  // start edge lands after mem[0] has already been read for the first word.
  always_ff @(posedge clk) begin
    if (load_en && state == S_IDLE) mem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench: two issuers (GAP=1/DRAIN=3 and GAP=0/DRAIN=0) compared each
// cycle against a schedule computed from word index, gap and drain arithmetic.
module tb_instr_issuer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ld_en_a, start_a, ld_en_b, start_b;
  logic [3:0]  ld_addr_a, ld_addr_b;
  logic [31:0] ld_data_a, ld_data_b;
  logic [4:0]  len_a, len_b;

  logic [31:0] instr_a, instr_b;
  logic [3:0]  pc_a, pc_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [4:0]  issued_a, issued_b, invalid_a, invalid_b;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];

  localparam int O_INSTR = 0, O_PC = 1, O_BUSY = 2, O_DONE = 3, O_ISSUED = 4, O_INVALID = 5;

  instr_issuer #(.DEPTH(16), .AW(4), .GAP(1), .DRAIN(3)) dut_a (
    .clk(clk), .rst(rst), .load_en(ld_en_a), .load_addr(ld_addr_a), .load_data(ld_data_a),
    .start(start_a), .length(len_a), .instruction(instr_a), .pc(pc_a), .busy(busy_a),
    .done(done_a), .issued_count(issued_a), .invalid_count(invalid_a));

  instr_issuer #(.DEPTH(16), .AW(4), .GAP(0), .DRAIN(0)) dut_b (
    .clk(clk), .rst(rst), .load_en(ld_en_b), .load_addr(ld_addr_b), .load_data(ld_data_b),
    .start(start_b), .length(len_b), .instruction(instr_b), .pc(pc_b), .busy(busy_b),
    .done(done_b), .issued_count(issued_b), .invalid_count(invalid_b));

  function automatic logic [31:0] obs(input bit sel, input int which);
    case (which)
      O_INSTR:   return sel ? instr_b : instr_a;
      O_PC:      return 32'(sel ? pc_b : pc_a);
      O_BUSY:    return 32'(sel ? busy_b : busy_a);
      O_DONE:    return 32'(sel ? done_b : done_a);
      O_ISSUED:  return 32'(sel ? issued_b : issued_a);
      default:   return 32'(sel ? invalid_b : invalid_a);
    endcase
  endfunction

  function automatic bit valid_op(input logic [31:0] w);
    int op;
    op = int'(w[5:0]);
    return op inside {2, 3, 4, 5, 6, 7, 8, 10, 12, 13, 15};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit sel, input int addr, input logic [31:0] data);
    if (sel) begin ld_en_b = 1'b1; ld_addr_b = 4'(addr); ld_data_b = data; end
    else     begin ld_en_a = 1'b1; ld_addr_a = 4'(addr); ld_data_a = data; end
    step();
    ld_en_a = 1'b0;
    ld_en_b = 1'b0;
    if (sel) mem_b[addr] = data;
    else     mem_a[addr] = data;
  endtask

  // One complete run; inject >= 0 pulses start and a write to mem[1] at that offset.
  task automatic run(input bit sel, input int len_req, input int inject);
    int g, d, L, total, words, bad, slot;
    string p;
    logic [31:0] prog [16];
    logic [31:0] exp_bus;
    g = sel ? 0 : 1;
    d = sel ? 0 : 3;
    L = (len_req > 16) ? 16 : len_req;
    p = sel ? "b" : "a";
    for (int i = 0; i < 16; i++) prog[i] = sel ? mem_b[i] : mem_a[i];
    if (sel) begin start_b = 1'b1; len_b = 5'(len_req); end
    else     begin start_a = 1'b1; len_a = 5'(len_req); end
    step();
    start_a = 1'b0; start_b = 1'b0; ld_en_a = 1'b0; ld_en_b = 1'b0;
    if (L == 0) begin
      check({p, "_zero_done"},    obs(sel, O_DONE), 32'd1);
      check({p, "_zero_busy"},    obs(sel, O_BUSY), 32'd0);
      check({p, "_zero_bus"},     obs(sel, O_INSTR), 32'd0);
      check({p, "_zero_issued"},  obs(sel, O_ISSUED), 32'd0);
      check({p, "_zero_invalid"}, obs(sel, O_INVALID), 32'd0);
      step();
      check({p, "_zero_done_fall"}, obs(sel, O_DONE), 32'd0);
      check({p, "_zero_busy_after"}, obs(sel, O_BUSY), 32'd0);
      return;
    end
    total = (L - 1) * (g + 1) + 1 + d;
    for (int j = 0; j <= total; j++) begin
      slot = j / (g + 1);
      words = (slot + 1 > L) ? L : slot + 1;
      exp_bus = (j % (g + 1) == 0 && slot < L) ? prog[slot] : 32'h0;
      bad = 0;
      for (int i = 0; i < words; i++) if (!valid_op(prog[i])) bad++;
      check($sformatf("%s_bus_j%0d", p, j),     obs(sel, O_INSTR), exp_bus);
      check($sformatf("%s_busy_j%0d", p, j),    obs(sel, O_BUSY), 32'(j < total));
      check($sformatf("%s_done_j%0d", p, j),    obs(sel, O_DONE), 32'(j == total));
      check($sformatf("%s_issued_j%0d", p, j),  obs(sel, O_ISSUED), 32'(words));
      check($sformatf("%s_invalid_j%0d", p, j), obs(sel, O_INVALID), 32'(bad));
      if (j == total) check({p, "_pc_end"}, obs(sel, O_PC), 32'(L - 1));
      if (j == inject) begin
        if (sel) begin start_b = 1'b1; len_b = 5'd2; ld_en_b = 1'b1; ld_addr_b = 4'd1; ld_data_b = 32'hFFFF_FFFF; end
        else     begin start_a = 1'b1; len_a = 5'd2; ld_en_a = 1'b1; ld_addr_a = 4'd1; ld_data_a = 32'hFFFF_FFFF; end
      end
      if (j < total) begin
        step();
        start_a = 1'b0; start_b = 1'b0; ld_en_a = 1'b0; ld_en_b = 1'b0;
      end
    end
    step();
    check({p, "_done_fall"}, obs(sel, O_DONE), 32'd0);
    check({p, "_idle_bus"},  obs(sel, O_INSTR), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    ld_en_a = 1'b0; start_a = 1'b0; ld_addr_a = '0; ld_data_a = '0; len_a = '0;
    ld_en_b = 1'b0; start_b = 1'b0; ld_addr_b = '0; ld_data_b = '0; len_b = '0;
    step();
    step();
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst_bus_%0d", s),     obs(s[0], O_INSTR), 32'd0);
      check($sformatf("rst_pc_%0d", s),      obs(s[0], O_PC), 32'd0);
      check($sformatf("rst_busy_%0d", s),    obs(s[0], O_BUSY), 32'd0);
      check($sformatf("rst_done_%0d", s),    obs(s[0], O_DONE), 32'd0);
      check($sformatf("rst_issued_%0d", s),  obs(s[0], O_ISSUED), 32'd0);
      check($sformatf("rst_invalid_%0d", s), obs(s[0], O_INVALID), 32'd0);
    end
    rst = 1'b0;

    // Random program images with opcodes biased into 0..15 for a mix of valid/invalid.
    for (int i = 0; i < 16; i++) begin
      w = $urandom; w[5:0] = 6'($urandom_range(0, 15)); load(1'b0, i, w);
      w = $urandom; w[5:0] = 6'($urandom_range(0, 15)); load(1'b1, i, w);
    end

    // Basic directed run: three words, one of which has an invalid opcode.
    load(1'b0, 0, 32'h0003_1045);
    load(1'b0, 1, 32'h0003_1048);
    load(1'b0, 2, 32'h0003_1041);
    run(1'b0, 3, -1);
    check("basic_invalid_total", obs(1'b0, O_INVALID), 32'd1);

    run(1'b0, 0, -1);
    run(1'b1, 0, -1);

    repeat (4) begin
      run(1'b0, int'($urandom_range(0, 20)), -1);
      run(1'b1, int'($urandom_range(0, 20)), -1);
    end

    // Clamp: 20 requested, 16 back-to-back words.
    run(1'b1, 20, -1);
    check("clamp_issued", obs(1'b1, O_ISSUED), 32'd16);

    // Start and load while busy are both ignored; rerun shows mem[1] unchanged.
    run(1'b0, 3, 1);
    run(1'b0, 3, -1);

    // Reset after the second word aborts the run with no done pulse.
    start_a = 1'b1; len_a = 5'd3;
    step();
    start_a = 1'b0;
    step();
    step();
    check("rst_mid_second_word", instr_a, mem_a[1]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_bus",     instr_a, 32'd0);
    check("rst_mid_busy",    32'(busy_a), 32'd0);
    check("rst_mid_done",    32'(done_a), 32'd0);
    check("rst_mid_issued",  32'(issued_a), 32'd0);
    check("rst_mid_invalid", 32'(invalid_a), 32'd0);
    for (int j = 0; j < 6; j++) begin
      step();
      check($sformatf("rst_mid_nodone_%0d", j), 32'(done_a), 32'd0);
    end
    run(1'b0, 3, -1);

    // Same-edge load of mem[0] and start: old word goes out first.
    ld_en_a = 1'b1; ld_addr_a = 4'd0; ld_data_a = 32'h0003_104F;
    run(1'b0, 3, -1);
    mem_a[0] = 32'h0003_104F;
    run(1'b0, 3, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
